snps_pll_sequencer: RTL

Power-up and lock sequencer for the Synopsys PLL macro in the nanosoc clock subsystem. It takes start, stop and reconfigure requests from software-visible control bits and drives the PLL's pwron, rst, gear_shift, bypass, enp and enr pins in the required order. It monitors lock with a timeout and recovers from loss of lock. It sits between the PLL APB register block and the PLL macro, and runs on the reference clock.

---
 rtl/snps_pll_sequencer_pkg.sv | 66 ++++++
 rtl/snps_pll_sync2.sv | 28 ++
 rtl/snps_pll_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/snps_pll_sequencer_pkg.sv
// snps_pll_sequencer_pkg
//   Shared definitions for the PLL power-up/lock sequencer: state encodings,
//   default timing parameters and the registered output bundle with its
//   per-state decode.
package snps_pll_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_OFF       = 3'd0,
      ST_PWRON     = 3'd1,
      ST_WAIT_LOCK = 3'd2,
      ST_SETTLE    = 3'd3,
      ST_RUN       = 3'd4,
      ST_FAULT     = 3'd5
   } pll_state_e;

   localparam int DEF_RST_CYCLES    = 100;   // 4 us at 25 MHz
   localparam int DEF_LOCK_TIMEOUT  = 4096;
   localparam int DEF_SETTLE_CYCLES = 16;
   localparam int DEF_CNT_W         = 16;

   typedef struct packed {
      logic pwron;
      logic rst;
      logic gear_shift;
      logic bypass;
      logic enp;
      logic enr;
      logic busy;
      logic locked;
   } pll_out_t;

   // Pin values for each state. Encodings 6/7 decode like OFF.
   function automatic pll_out_t decode_outputs(input pll_state_e s);
      pll_out_t o;
      o = '{pwron: 1'b0, rst: 1'b1, gear_shift: 1'b0, bypass: 1'b1,
            enp: 1'b0, enr: 1'b0, busy: 1'b0, locked: 1'b0};
      case (s)
         ST_PWRON: begin
            o.pwron = 1'b1;
            o.busy  = 1'b1;
         end
         ST_WAIT_LOCK: begin
            o.pwron      = 1'b1;
            o.rst        = 1'b0;
            o.gear_shift = 1'b1;
            o.busy       = 1'b1;
         end
         ST_SETTLE: begin
            o.pwron = 1'b1;
            o.rst   = 1'b0;
            o.busy  = 1'b1;
         end
         ST_RUN: begin
            o.pwron  = 1'b1;
            o.rst    = 1'b0;
            o.bypass = 1'b0;
            o.enp    = 1'b1;
            o.enr    = 1'b1;
            o.locked = 1'b1;
         end
         default: ;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/snps_pll_sync2.sv
// snps_pll_sync2
//   Generic 2-flop synchroniser for asynchronous status inputs.
//   clk   : destination clock
//   reset : synchronous, active-high; clears both flop stages
//   d     : asynchronous input
//   q     : synchronised output (2 cycles of latency)
module snps_pll_sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/snps_pll_sequencer.sv
// snps_pll_sequencer
//   Power-up and lock sequencer for the PLL macro, running on ref_clk.
//   Inputs : ref_clk, reset (sync, active-high), start, stop, cfg_update,
//            pll_lock (async raw lock)
//   Outputs: pll_pwron, pll_rst, pll_gear_shift, pll_bypass, pll_enp,
//            pll_enr (PLL pins); busy, locked, timeout_err (sticky),
//            lock_lost (sticky), state (3-bit encoding)
//   All outputs are registered and decoded from the next state, so pins
//   move in the same cycle as the state register.
module snps_pll_sequencer
   import snps_pll_sequencer_pkg::*;
#(
   parameter int RST_CYCLES    = DEF_RST_CYCLES,
   parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic       ref_clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       cfg_update,
   input  logic       pll_lock,
   output logic       pll_pwron,
   output logic       pll_rst,
   output logic       pll_gear_shift,
   output logic       pll_bypass,
   output logic       pll_enp,
   output logic       pll_enr,
   output logic       busy,
   output logic       locked,
   output logic       timeout_err,
   output logic       lock_lost,
   output logic [2:0] state
);

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   pll_state_e       state_q, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             cnt_clr, cnt_inc;
   logic             set_to, set_lost, clr_flags;
   logic             lock_s;
   pll_out_t         out_nxt;

   snps_pll_sync2 #(.WIDTH(1)) u_lock_sync (
      .clk   (ref_clk),
      .reset (reset),
      .d     (pll_lock),
      .q     (lock_s)
   );

   // State register, shared counter, sticky flags and registered pins.
   always_ff @(posedge ref_clk) begin
      if (reset) begin
         state_q        <= ST_OFF;
         cnt            <= '0;
         timeout_err    <= 1'b0;
         lock_lost      <= 1'b0;
         pll_pwron      <= 1'b0;
         pll_rst        <= 1'b1;
         pll_gear_shift <= 1'b0;
         pll_bypass     <= 1'b1;
         pll_enp        <= 1'b0;
         pll_enr        <= 1'b0;
         busy           <= 1'b0;
         locked         <= 1'b0;
      end else begin
         state_q <= state_nxt;
         // Saturating counter: holds at all-ones rather than wrapping.
         if (cnt_clr)
            cnt <= '0;
         else if (cnt_inc && (cnt != '1))
            cnt <= cnt + 1'b1;
         if (clr_flags) begin
            timeout_err <= 1'b0;
            lock_lost   <= 1'b0;
         end else begin
            if (set_to)   timeout_err <= 1'b1;
            if (set_lost) lock_lost   <= 1'b1;
         end
         pll_pwron      <= out_nxt.pwron;
         pll_rst        <= out_nxt.rst;
         pll_gear_shift <= out_nxt.gear_shift;
         pll_bypass     <= out_nxt.bypass;
         pll_enp        <= out_nxt.enp;
         pll_enr        <= out_nxt.enr;
         busy           <= out_nxt.busy;
         locked         <= out_nxt.locked;
      end
   end

   // Next state. stop > cfg_update > start > normal progression.
   always_comb begin
      state_nxt = state_q;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      set_to    = 1'b0;
      set_lost  = 1'b0;
      clr_flags = 1'b0;
      if (stop) begin
         state_nxt = ST_OFF;
      end else if (cfg_update && (state_q == ST_WAIT_LOCK ||
                                  state_q == ST_SETTLE || state_q == ST_RUN)) begin
         state_nxt = ST_PWRON;
         cnt_clr   = 1'b1;
      end else begin
         case (state_q)
            ST_OFF, ST_FAULT: begin
               if (start) begin
                  state_nxt = ST_PWRON;
                  cnt_clr   = 1'b1;
                  clr_flags = 1'b1;
               end
            end
            ST_PWRON: begin
               if (cnt >= RST_LAST) begin
                  state_nxt = ST_WAIT_LOCK;
                  cnt_clr   = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            ST_WAIT_LOCK: begin
               if (lock_s) begin
                  state_nxt = ST_SETTLE;
                  cnt_clr   = 1'b1;
               end else if (cnt >= TO_LAST) begin
                  state_nxt = ST_FAULT;
                  set_to    = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            ST_SETTLE: begin
               // Counter tracks consecutive locked cycles; a dropout restarts it.
               if (!lock_s) begin
                  cnt_clr = 1'b1;
               end else if (cnt >= SETTLE_LAST) begin
                  state_nxt = ST_RUN;
                  cnt_clr   = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            ST_RUN: begin
               if (!lock_s) begin
                  state_nxt = ST_WAIT_LOCK;
                  cnt_clr   = 1'b1;
                  set_lost  = 1'b1;
               end
            end
            default: state_nxt = ST_OFF;
         endcase
      end
   end

   // Output decode from the next state; registered above.
   always_comb begin
      out_nxt = decode_outputs(state_nxt);
   end

   assign state = state_q;

endmodule
